// File: rtl/fpga_cfg_loader.sv
// Byte-serial configuration loader: deframes SYNC/id/payload/checksum packets
// from a valid/ready byte stream and commits them to the fabric config buses.
module fpga_cfg_loader (
  input  logic         clk,
  input  logic         reset,
  input  logic [7:0]   s_data,
  input  logic         s_valid,
  output logic         s_ready,
  output logic [143:0] LUT_in,
  output logic [239:0] SB_in,
  output logic [419:0] CB_in,
  output logic [35:0]  sel_direction_BLEout,
  output logic [17:0]  sel_direction,
  output logic [8:0]   BLE_dff_select,
  output logic [3:0]   IO_sel,
  output logic [6:0]   loaded,
  output logic         cfg_done,
  output logic         crc_err,
  output logic         tgt_err
);

  // state   | meaning
  // IDLE    | hunting for SYNC, other bytes dropped
  // TARGET  | next byte is the target id
  // PAYLOAD | shifting payload bytes into shadow
  // CHECK   | next byte is the checksum
  // COMMIT  | one cycle, write bus on match, stall input
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TARGET,
    ST_PAYLOAD,
    ST_CHECK,
    ST_COMMIT
  } state_t;

  localparam logic [7:0] SYNC = 8'hA5;

  state_t       state_q, state_d;
  logic         ready_en_q;
  logic [6:0]   tgt_q;
  logic [5:0]   cnt_q;
  logic [7:0]   csum_q;
  logic         match_q;
  // Widest target is 420 bits; anything shifted above that is pad only.
  logic [419:0] shadow_q;
  logic         accept;
  logic         id_ok;
  logic [6:0]   loaded_nx;

  function automatic logic [5:0] last_idx(input logic [2:0] id);
    case (id)
      3'd0:    return 6'd17;
      3'd1:    return 6'd29;
      3'd2:    return 6'd52;
      3'd3:    return 6'd4;
      3'd4:    return 6'd2;
      3'd5:    return 6'd1;
      default: return 6'd0;
    endcase
  endfunction

  assign s_ready = ready_en_q & (state_q != ST_COMMIT);
  assign accept  = s_valid & s_ready;
  assign id_ok   = (s_data < 8'd7);

  always_comb begin
    loaded_nx = loaded | (7'd1 << tgt_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ready_en_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (accept && s_data == SYNC) state_d = ST_TARGET;
      ST_TARGET:  if (accept) state_d = id_ok ? ST_PAYLOAD : ST_IDLE;
      ST_PAYLOAD: if (accept && cnt_q == 6'd0) state_d = ST_CHECK;
      ST_CHECK:   if (accept) state_d = ST_COMMIT;
      ST_COMMIT:  state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tgt_q                <= '0;
      cnt_q                <= '0;
      csum_q               <= '0;
      match_q              <= 1'b0;
      shadow_q             <= '0;
      LUT_in               <= '0;
      SB_in                <= '0;
      CB_in                <= '0;
      sel_direction_BLEout <= '0;
      sel_direction        <= '0;
      BLE_dff_select       <= '0;
      IO_sel               <= '0;
      loaded               <= '0;
      cfg_done             <= 1'b0;
      crc_err              <= 1'b0;
      tgt_err              <= 1'b0;
    end else begin
      crc_err <= 1'b0;
      tgt_err <= 1'b0;
      case (state_q)
        ST_TARGET: begin
          if (accept) begin
            if (id_ok) begin
              tgt_q    <= s_data[6:0];
              cnt_q    <= last_idx(s_data[2:0]);
              csum_q   <= s_data;
              shadow_q <= '0;
            end else begin
              tgt_err <= 1'b1;
            end
          end
        end
        ST_PAYLOAD: begin
          if (accept) begin
            shadow_q <= {shadow_q[411:0], s_data};
            csum_q   <= csum_q ^ s_data;
            cnt_q    <= cnt_q - 6'd1;
          end
        end
        ST_CHECK: begin
          if (accept) match_q <= (csum_q == s_data);
        end
        ST_COMMIT: begin
          if (match_q) begin
            case (tgt_q)
              7'd0:    LUT_in               <= shadow_q[143:0];
              7'd1:    SB_in                <= shadow_q[239:0];
              7'd2:    CB_in                <= shadow_q[419:0];
              7'd3:    sel_direction_BLEout <= shadow_q[35:0];
              7'd4:    sel_direction        <= shadow_q[17:0];
              7'd5:    BLE_dff_select       <= shadow_q[8:0];
              7'd6:    IO_sel               <= shadow_q[3:0];
              default: ;
            endcase
            loaded   <= loaded_nx;
            cfg_done <= &loaded_nx;
          end else begin
            crc_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// Self-checking bench for fpga_cfg_loader: hand-computed frame table, directed
// corner sequences, and randomized frames checked against a byte-level model.
module tb_fpga_cfg_loader;

  logic         clk = 1'b0;
  logic         reset;
  logic [7:0]   s_data;
  logic         s_valid;
  logic         s_ready;
  logic [143:0] LUT_in;
  logic [239:0] SB_in;
  logic [419:0] CB_in;
  logic [35:0]  sel_direction_BLEout;
  logic [17:0]  sel_direction;
  logic [8:0]   BLE_dff_select;
  logic [3:0]   IO_sel;
  logic [6:0]   loaded;
  logic         cfg_done;
  logic         crc_err;
  logic         tgt_err;

  always #5 clk = ~clk;

  fpga_cfg_loader dut (
    .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .LUT_in(LUT_in), .SB_in(SB_in), .CB_in(CB_in),
    .sel_direction_BLEout(sel_direction_BLEout), .sel_direction(sel_direction),
    .BLE_dff_select(BLE_dff_select), .IO_sel(IO_sel), .loaded(loaded),
    .cfg_done(cfg_done), .crc_err(crc_err), .tgt_err(tgt_err)
  );

  int n_vec = 0;
  int n_err = 0;
  int WID[7] = '{144, 240, 420, 36, 18, 9, 4};
  int NB[7]  = '{18, 30, 53, 5, 3, 2, 1};

  // reference model state
  logic [423:0] exp_val [7];
  logic [6:0]   exp_loaded;
  logic [7:0]   pbuf [64];
  int           plen;
  logic         last_crc;
  logic [423:0] got;

  typedef struct {
    logic [7:0]  id;
    int          n;
    logic [39:0] pay;
    logic [7:0]  csum;
    bit          crc;
    logic [35:0] exp;
  } vec_t;
  vec_t tbl [10];

  task automatic chk(input string name, input logic [423:0] act, input logic [423:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [423:0] bus_of(input int t);
    logic [423:0] r;
    r = '0;
    case (t)
      0: r[143:0] = LUT_in;
      1: r[239:0] = SB_in;
      2: r[419:0] = CB_in;
      3: r[35:0]  = sel_direction_BLEout;
      4: r[17:0]  = sel_direction;
      5: r[8:0]   = BLE_dff_select;
      6: r[3:0]   = IO_sel;
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] calc_csum(input logic [7:0] id);
    logic [7:0] x;
    x = id;
    for (int j = 0; j < plen; j++) x = x ^ pbuf[j];
    return x;
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int  t;
    int  k;
    bit  rdy;
    @(negedge clk);
    if (gaps) begin
      k = $urandom_range(0, 3);
      if (k > 0) begin
        s_valid = 1'b0;
        repeat (k) @(negedge clk);
      end
    end
    s_valid = 1'b1;
    s_data  = b;
    t = 0;
    forever begin
      rdy = s_ready;
      @(posedge clk);
      if (rdy) break;
      t++;
      if (t > 40) begin
        chk("byte_accept_timeout", 1'b0, 1'b1);
        break;
      end
      @(negedge clk);
    end
  endtask

  // Sends SYNC, id, pbuf[0..plen-1], csum; returns at the negedge after commit.
  task automatic send_frame(input logic [7:0] id, input logic [7:0] csum, input bit gaps);
    logic [423:0] v, mask, one;
    bit good;
    int t;
    t    = int'(id);
    good = (calc_csum(id) == csum);
    send_byte(8'hA5, gaps);
    send_byte(id, gaps);
    for (int j = 0; j < plen; j++) send_byte(pbuf[j], gaps);
    send_byte(csum, gaps);
    @(negedge clk);
    chk("ready_in_commit", s_ready, 1'b0);
    s_valid = 1'b0;
    if (good) begin
      v = '0;
      for (int j = 0; j < plen; j++) v = (v << 8) | {416'b0, pbuf[j]};
      one  = 1;
      mask = (one << WID[t]) - 1;
      exp_val[t]    = v & mask;
      exp_loaded[t] = 1'b1;
    end
    @(negedge clk);
    last_crc = crc_err;
    chk("crc_err", crc_err, !good);
    chk($sformatf("bus%0d", t), bus_of(t), exp_val[t]);
    chk("loaded", loaded, exp_loaded);
    chk("cfg_done", cfg_done, (exp_loaded == 7'h7F));
    chk("ready_after_commit", s_ready, 1'b1);
    chk("tgt_err_quiet", tgt_err, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    for (int t = 0; t < 7; t++) chk($sformatf("%s_bus%0d", tag, t), bus_of(t), '0);
    chk({tag, "_loaded"}, loaded, '0);
    chk({tag, "_cfg_done"}, cfg_done, 1'b0);
    chk({tag, "_crc_err"}, crc_err, 1'b0);
    chk({tag, "_tgt_err"}, tgt_err, 1'b0);
    chk({tag, "_s_ready"}, s_ready, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] g, cs;
    int t;

    //           id     n  payload           csum   crc   expected bus
    tbl[0] = '{8'd6, 1, 40'h0F,          8'h00, 1'b1, 36'h0};
    tbl[1] = '{8'd6, 1, 40'h05,          8'h03, 1'b0, 36'h5};
    tbl[2] = '{8'd6, 1, 40'h0F,          8'h09, 1'b0, 36'hF};
    tbl[3] = '{8'd4, 3, 40'h0094F2,      8'h62, 1'b0, 36'h094F2};
    tbl[4] = '{8'd5, 2, 40'h01FF,        8'hFB, 1'b0, 36'h1FF};
    tbl[5] = '{8'd5, 2, 40'hFEAB,        8'h50, 1'b0, 36'h0AB};
    tbl[6] = '{8'd3, 5, 40'hF123456789,  8'h7A, 1'b0, 36'h123456789};
    tbl[7] = '{8'd4, 3, 40'hFFFFFF,      8'h00, 1'b1, 36'h094F2};
    tbl[8] = '{8'd6, 1, 40'hA5,          8'hA3, 1'b0, 36'h5};
    tbl[9] = '{8'd3, 5, 40'h0,           8'h03, 1'b0, 36'h0};

    for (int i = 0; i < 7; i++) exp_val[i] = '0;
    exp_loaded = '0;

    reset   = 1'b0;
    s_valid = 1'b0;
    s_data  = 8'h00;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b1;
    #1 chk("ready_before_first_edge", s_ready, 1'b0);
    @(posedge clk);
    #1 chk("ready_first_edge", s_ready, 1'b1);

    // hand-computed frame table
    for (int i = 0; i < 10; i++) begin
      plen = tbl[i].n;
      for (int j = 0; j < plen; j++) pbuf[j] = tbl[i].pay[8*(plen-1-j) +: 8];
      send_frame(tbl[i].id, tbl[i].csum, 1'b0);
      got = bus_of(int'(tbl[i].id));
      chk($sformatf("tbl%0d_bus", i), got[35:0], tbl[i].exp);
      chk($sformatf("tbl%0d_crc", i), last_crc, tbl[i].crc);
      @(negedge clk);
      chk("crc_one_cycle", crc_err, 1'b0);
    end

    // sel_direction frame again with random valid gaps
    plen = 3;
    pbuf[0] = 8'h00; pbuf[1] = 8'h00; pbuf[2] = 8'h00;
    send_frame(8'd4, 8'h04, 1'b0);
    pbuf[0] = 8'h00; pbuf[1] = 8'h94; pbuf[2] = 8'hF2;
    send_frame(8'd4, 8'h62, 1'b1);
    chk("gapped_sel_direction", sel_direction, 18'b00_10_01_01_00_11_11_00_10);

    // leading garbage, then a bad target id
    send_byte(8'h00, 1'b0);
    send_byte(8'hFF, 1'b0);
    send_byte(8'h5A, 1'b0);
    send_byte(8'hA5, 1'b0);
    send_byte(8'h07, 1'b0);
    @(negedge clk);
    s_valid = 1'b0;
    chk("tgt_err_pulse", tgt_err, 1'b1);
    chk("tgt_err_no_crc", crc_err, 1'b0);
    @(negedge clk);
    chk("tgt_err_one_cycle", tgt_err, 1'b0);
    chk("tgt_err_loaded", loaded, exp_loaded);
    plen = 1;
    pbuf[0] = 8'h03;
    send_frame(8'd6, 8'h05, 1'b0);
    chk("after_bad_id_io", IO_sel, 4'h3);

    // randomized back-to-back frames against the model
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        g = 8'($urandom_range(0, 255));
        if (g == 8'hA5) g = 8'h00;
        send_byte(g, 1'b0);
      end
      t    = $urandom_range(0, 6);
      plen = NB[t];
      for (int j = 0; j < plen; j++) begin
        pbuf[j] = 8'($urandom_range(0, 255));
        if ($urandom_range(0, 7) == 0) pbuf[j] = 8'hA5;
      end
      cs = calc_csum(8'(t));
      if ($urandom_range(0, 3) == 0) cs = cs ^ 8'($urandom_range(1, 255));
      send_frame(8'(t), cs, 1'($urandom_range(0, 1)));
    end

    // reset in the middle of a CB_in payload
    send_byte(8'hA5, 1'b0);
    send_byte(8'h02, 1'b0);
    for (int j = 0; j < 19; j++) send_byte(8'($urandom_range(0, 255)), 1'b0);
    #2;
    reset   = 1'b0;
    s_valid = 1'b0;
    #1;
    check_all_zero("midreset");
    for (int i = 0; i < 7; i++) exp_val[i] = '0;
    exp_loaded = '0;
    @(negedge clk);
    reset = 1'b1;
    #1 chk("midreset_ready_low", s_ready, 1'b0);
    @(posedge clk);
    #1 chk("midreset_ready_high", s_ready, 1'b1);
    plen = 53;
    for (int j = 0; j < plen; j++) pbuf[j] = 8'($urandom_range(0, 255));
    send_frame(8'd2, calc_csum(8'd2), 1'b0);

    // load the remaining targets; cfg_done must rise with the last commit
    for (int k = 0; k < 6; k++) begin
      t = (k == 0) ? 0 : (k == 1) ? 1 : (k == 2) ? 3 : (k == 3) ? 4 : (k == 4) ? 5 : 6;
      plen = NB[t];
      for (int j = 0; j < plen; j++) pbuf[j] = 8'($urandom_range(0, 255));
      if (t == 0) begin pbuf[3] = 8'hA5; pbuf[4] = 8'hA5; end
      if (t == 1) pbuf[0] = 8'hA5;
      send_frame(8'(t), calc_csum(8'(t)), 1'b0);
      chk($sformatf("cfg_done_after_t%0d", t), cfg_done, (t == 6));
    end
    chk("final_loaded", loaded, 7'h7F);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
